// File: rtl/clnk_readout_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clnk_readout_ctrl
// Description : Queues matched L1As and streams one full event per L1A from
//               the sample buffer to the channel-link output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module clnk_readout_ctrl #(
    parameter int NSAMP    = 8,
    parameter int WRDS_SMP = 96,
    parameter int MAX_PEND = 7,
    parameter int GAP_CYC  = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        L1A_MATCH,
    input  logic        RD_RDY,
    input  logic [15:0] RD_DATA,
    output logic        RD_EN,
    output logic [15:0] FRAME_DATA,
    output logic        DVALID,
    output logic        LAST_WRD,
    output logic        OVLP_MUX,
    output logic        MLT_OVLP,
    output logic        BUSY,
    output logic [3:0]  PEND_CNT,
    output logic        OVFL
);

    localparam int EVT_WORDS = NSAMP * WRDS_SMP;
    localparam int WCW       = $clog2(EVT_WORDS);
    localparam int GCW       = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [WCW-1:0] c_wcnt_last = WCW'(EVT_WORDS - 1);
    localparam logic [GCW-1:0] c_gap_last  = GCW'(GAP_CYC - 1);
    localparam logic [3:0]     c_max_pend  = 4'(MAX_PEND);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_READ = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       pend_q, pend_d;
    logic             ovfl_q, ovfl_d;
    logic [WCW-1:0]   wcnt_q, wcnt_d;
    logic [GCW-1:0]   gcnt_q, gcnt_d;
    logic             ovl_q, ovl_d;
    logic             mov_q, mov_d;

    logic             s1_vld_q, s1_vld_d;
    logic             s1_last_q, s1_last_d;
    logic             s1_ovl_q, s1_ovl_d;
    logic             s1_mov_q, s1_mov_d;
    logic             dvalid_q, dvalid_d;
    logic             last_q, last_d;
    logic [15:0]      frame_q, frame_d;
    logic             ovlp_q, ovlp_d;
    logic             mlt_q, mlt_d;

    logic             w_rd_en;
    logic             w_last_rd;
    logic             w_inc;
    logic             w_dec;

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        ovfl_d    = ovfl_q;
        wcnt_d    = wcnt_q;
        gcnt_d    = gcnt_q;
        ovl_d     = ovl_q;
        mov_d     = mov_q;
        w_rd_en   = 1'b0;
        w_last_rd = 1'b0;

        w_inc = L1A_MATCH;
        w_dec = (state_q == S_WAIT) && RD_RDY;

        // A simultaneous accept and start cancel out, so saturation only bites
        // when no event is leaving the queue in the same cycle.
        if (w_inc && !w_dec) begin
            if (pend_q == c_max_pend) begin
                ovfl_d = 1'b1;
            end else begin
                pend_d = pend_q + 4'd1;
            end
        end else if (w_dec && !w_inc) begin
            pend_d = pend_q - 4'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (pend_q != 4'd0) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (RD_RDY) begin
                    state_d = S_READ;
                    wcnt_d  = '0;
                    ovl_d   = (pend_d >= 4'd1);
                    mov_d   = (pend_d >= 4'd2);
                end
            end
            S_READ: begin
                w_rd_en = 1'b1;
                if (wcnt_q == c_wcnt_last) begin
                    w_last_rd = 1'b1;
                    state_d   = S_GAP;
                    gcnt_d    = '0;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gcnt_q == c_gap_last) begin
                    state_d = S_IDLE;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Two-stage output pipeline: stage 1 tracks the buffer's read latency,
    // stage 2 registers the word together with its framing flags.
    always_comb begin
        s1_vld_d  = w_rd_en;
        s1_last_d = w_last_rd;
        s1_ovl_d  = w_rd_en & ovl_q;
        s1_mov_d  = w_rd_en & mov_q;
        dvalid_d  = s1_vld_q;
        last_d    = s1_last_q;
        frame_d   = s1_vld_q ? RD_DATA : frame_q;
        ovlp_d    = s1_ovl_q;
        mlt_d     = s1_mov_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            pend_q    <= 4'd0;
            ovfl_q    <= 1'b0;
            wcnt_q    <= '0;
            gcnt_q    <= '0;
            ovl_q     <= 1'b0;
            mov_q     <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
            s1_ovl_q  <= 1'b0;
            s1_mov_q  <= 1'b0;
            dvalid_q  <= 1'b0;
            last_q    <= 1'b0;
            frame_q   <= 16'd0;
            ovlp_q    <= 1'b0;
            mlt_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            ovfl_q    <= ovfl_d;
            wcnt_q    <= wcnt_d;
            gcnt_q    <= gcnt_d;
            ovl_q     <= ovl_d;
            mov_q     <= mov_d;
            s1_vld_q  <= s1_vld_d;
            s1_last_q <= s1_last_d;
            s1_ovl_q  <= s1_ovl_d;
            s1_mov_q  <= s1_mov_d;
            dvalid_q  <= dvalid_d;
            last_q    <= last_d;
            frame_q   <= frame_d;
            ovlp_q    <= ovlp_d;
            mlt_q     <= mlt_d;
        end
    end

    assign RD_EN      = w_rd_en;
    assign FRAME_DATA = frame_q;
    assign DVALID     = dvalid_q;
    assign LAST_WRD   = last_q;
    assign OVLP_MUX   = ovlp_q;
    assign MLT_OVLP   = mlt_q;
    assign BUSY       = (state_q != S_IDLE);
    assign PEND_CNT   = pend_q;
    assign OVFL       = ovfl_q;

endmodule
`default_nettype wire

// File: tb/tb_clnk_readout_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clnk_readout_ctrl
// Description : Directed self-checking bench for clnk_readout_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clnk_readout_ctrl;

    localparam int EVT_WORDS = 768;
    localparam int GAP_CYC   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        l1a = 1'b0;
    logic        rd_rdy = 1'b0;
    logic [15:0] rd_data = 16'd0;
    logic        rd_en;
    logic [15:0] frame_data;
    logic        dvalid;
    logic        last_wrd;
    logic        ovlp_mux;
    logic        mlt_ovlp;
    logic        busy;
    logic [3:0]  pend_cnt;
    logic        ovfl;

    int checks = 0;
    int errors = 0;

    clnk_readout_ctrl dut (
        .CLK        (clk),
        .RST        (rst),
        .L1A_MATCH  (l1a),
        .RD_RDY     (rd_rdy),
        .RD_DATA    (rd_data),
        .RD_EN      (rd_en),
        .FRAME_DATA (frame_data),
        .DVALID     (dvalid),
        .LAST_WRD   (last_wrd),
        .OVLP_MUX   (ovlp_mux),
        .MLT_OVLP   (mlt_ovlp),
        .BUSY       (busy),
        .PEND_CNT   (pend_cnt),
        .OVFL       (ovfl)
    );

    always #5 clk = ~clk;

    // Buffer model: an incrementing word appears the cycle after each read strobe.
    logic [15:0] rd_ptr = 16'd0;
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data <= rd_ptr;
            rd_ptr  <= rd_ptr + 16'd1;
        end
    end

    // Output observer: slices the DVALID stream into events and records them.
    int          cyc = 0;
    int          evt_n, first_rden, first_dv, rden_total, dv_total;
    int          run_len, low_len, gap_min;
    int          last_bad, data_bad, flag_bad, out_bad;
    bit          in_run, had_event, run_ovl, run_mov;
    int          ev_len [16];
    bit          ev_ovl [16];
    bit          ev_mov [16];
    logic [15:0] exp_data = 16'd0;

    task automatic clear_mon();
        evt_n = 0; first_rden = -1; first_dv = -1; rden_total = 0; dv_total = 0;
        run_len = 0; low_len = 0; gap_min = 1000000; in_run = 0; had_event = 0;
        last_bad = 0; data_bad = 0; flag_bad = 0; out_bad = 0;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rd_en) begin
            rden_total++;
            if (first_rden < 0) first_rden = cyc;
        end
        if (rst) begin
            in_run  = 0;
            run_len = 0;
        end else if (dvalid) begin
            dv_total++;
            if (first_dv < 0) first_dv = cyc;
            if (!in_run) begin
                in_run  = 1;
                run_len = 0;
                run_ovl = ovlp_mux;
                run_mov = mlt_ovlp;
                if (had_event && low_len < gap_min) gap_min = low_len;
            end
            if (ovlp_mux !== run_ovl || mlt_ovlp !== run_mov) flag_bad++;
            if (frame_data !== exp_data) data_bad++;
            exp_data = exp_data + 16'd1;
            if (last_wrd !== (run_len == EVT_WORDS - 1)) last_bad++;
            run_len++;
        end else begin
            if (in_run) begin
                if (evt_n < 16) begin
                    ev_len[evt_n] = run_len;
                    ev_ovl[evt_n] = run_ovl;
                    ev_mov[evt_n] = run_mov;
                end
                evt_n++;
                in_run    = 0;
                had_event = 1;
                low_len   = 0;
            end
            low_len++;
            if (last_wrd || ovlp_mux || mlt_ovlp) out_bad++;
        end
    end

    task automatic wait_events(input int n, input int bound);
        int k = 0;
        while (evt_n < n && k < bound) begin
            @(negedge clk);
            k++;
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (dvalid !== 1'b0) begin errors++; $display("FAIL reset_dvalid got %b exp 0", dvalid); end
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b exp 0", rd_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (pend_cnt !== 4'd0) begin errors++; $display("FAIL reset_pend got %0d exp 0", pend_cnt); end
        checks++;
        if ({last_wrd, ovlp_mux, mlt_ovlp, ovfl, frame_data} !== 20'd0) begin
            errors++;
            $display("FAIL reset_flags got last=%b ovl=%b mov=%b ovfl=%b frame=%h exp all 0",
                     last_wrd, ovlp_mux, mlt_ovlp, ovfl, frame_data);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single();
        clear_mon();
        rd_rdy = 1'b1;
        l1a = 1'b1;
        @(negedge clk);
        l1a = 1'b0;
        checks++; if (pend_cnt !== 4'd1) begin errors++; $display("FAIL single_pend_inc got %0d exp 1", pend_cnt); end
        wait_events(1, 1500);
        checks++; if (evt_n != 1) begin errors++; $display("FAIL single_evt_count got %0d exp 1", evt_n); end
        checks++; if (ev_len[0] != EVT_WORDS) begin errors++; $display("FAIL single_len got %0d exp %0d", ev_len[0], EVT_WORDS); end
        checks++; if (rden_total != EVT_WORDS) begin errors++; $display("FAIL single_rden got %0d exp %0d", rden_total, EVT_WORDS); end
        checks++; if (first_dv - first_rden != 2) begin errors++; $display("FAIL single_latency got %0d exp 2", first_dv - first_rden); end
        checks++; if ({ev_ovl[0], ev_mov[0]} !== 2'b00) begin errors++; $display("FAIL single_ovl got %b%b exp 00", ev_ovl[0], ev_mov[0]); end
        checks++; if (last_bad != 0) begin errors++; $display("FAIL single_last got %0d bad exp 0", last_bad); end
        checks++; if (data_bad != 0) begin errors++; $display("FAIL single_data got %0d bad exp 0", data_bad); end
        checks++; if (pend_cnt !== 4'd0) begin errors++; $display("FAIL single_pend_end got %0d exp 0", pend_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b exp 0", busy); end
    endtask

    task automatic test_two();
        clear_mon();
        rd_rdy = 1'b1;
        l1a = 1'b1; @(negedge clk);
        l1a = 1'b0; @(negedge clk);
        // Second L1A lands on the WAIT->READ cycle: count holds and ovl latches 1.
        l1a = 1'b1; @(negedge clk);
        l1a = 1'b0;
        checks++; if (pend_cnt !== 4'd1) begin errors++; $display("FAIL two_pend_hold got %0d exp 1", pend_cnt); end
        wait_events(2, 2500);
        checks++; if (evt_n != 2) begin errors++; $display("FAIL two_evt_count got %0d exp 2", evt_n); end
        checks++; if ({ev_ovl[0], ev_mov[0]} !== 2'b10) begin errors++; $display("FAIL two_evt1_ovl got %b%b exp 10", ev_ovl[0], ev_mov[0]); end
        checks++; if ({ev_ovl[1], ev_mov[1]} !== 2'b00) begin errors++; $display("FAIL two_evt2_ovl got %b%b exp 00", ev_ovl[1], ev_mov[1]); end
        checks++; if (ev_len[0] != EVT_WORDS || ev_len[1] != EVT_WORDS) begin errors++; $display("FAIL two_len got %0d,%0d exp %0d", ev_len[0], ev_len[1], EVT_WORDS); end
        checks++; if (gap_min < GAP_CYC) begin errors++; $display("FAIL two_gap got %0d exp >=%0d", gap_min, GAP_CYC); end
        checks++; if (flag_bad != 0 || out_bad != 0) begin errors++; $display("FAIL two_flag_window got %0d/%0d exp 0/0", flag_bad, out_bad); end
        checks++; if (last_bad != 0 || data_bad != 0) begin errors++; $display("FAIL two_last_data got %0d/%0d exp 0/0", last_bad, data_bad); end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        rd_rdy = 1'b1;
        l1a = 1'b1;
        repeat (3) @(negedge clk);
        l1a = 1'b0;
        wait_events(3, 3500);
        checks++; if (evt_n != 3) begin errors++; $display("FAIL b2b_evt_count got %0d exp 3", evt_n); end
        checks++; if ({ev_ovl[0], ev_mov[0]} !== 2'b11) begin errors++; $display("FAIL b2b_evt1_ovl got %b%b exp 11", ev_ovl[0], ev_mov[0]); end
        checks++; if ({ev_ovl[1], ev_mov[1]} !== 2'b10) begin errors++; $display("FAIL b2b_evt2_ovl got %b%b exp 10", ev_ovl[1], ev_mov[1]); end
        checks++; if ({ev_ovl[2], ev_mov[2]} !== 2'b00) begin errors++; $display("FAIL b2b_evt3_ovl got %b%b exp 00", ev_ovl[2], ev_mov[2]); end
        checks++; if (flag_bad != 0 || out_bad != 0) begin errors++; $display("FAIL b2b_flag_window got %0d/%0d exp 0/0", flag_bad, out_bad); end
        checks++; if (dv_total != 3 * EVT_WORDS) begin errors++; $display("FAIL b2b_dv_total got %0d exp %0d", dv_total, 3 * EVT_WORDS); end
    endtask

    task automatic test_wait_rdy();
        int rd_seen = 0;
        clear_mon();
        rd_rdy = 1'b0;
        l1a = 1'b1; @(negedge clk);
        l1a = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (rd_en) rd_seen++;
        end
        checks++; if (rd_seen != 0) begin errors++; $display("FAIL wait_rd_en got %0d strobes exp 0", rd_seen); end
        checks++; if (busy !== 1'b1 || pend_cnt !== 4'd1) begin errors++; $display("FAIL wait_state got busy=%b pend=%0d exp 1/1", busy, pend_cnt); end
        rd_rdy = 1'b1;
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL wait_rd_en_early got %b exp 0", rd_en); end
        @(negedge clk);
        checks++; if (rd_en !== 1'b1) begin errors++; $display("FAIL wait_rd_en_start got %b exp 1", rd_en); end
        wait_events(1, 1500);
        checks++; if (evt_n != 1 || ev_len[0] != EVT_WORDS) begin errors++; $display("FAIL wait_evt got n=%0d len=%0d exp 1/%0d", evt_n, ev_len[0], EVT_WORDS); end
    endtask

    task automatic test_ovfl();
        clear_mon();
        rd_rdy = 1'b0;
        l1a = 1'b1;
        repeat (9) @(negedge clk);
        l1a = 1'b0;
        @(negedge clk);
        checks++; if (pend_cnt !== 4'd7) begin errors++; $display("FAIL ovfl_pend_sat got %0d exp 7", pend_cnt); end
        checks++; if (ovfl !== 1'b1) begin errors++; $display("FAIL ovfl_set got %b exp 1", ovfl); end
        checks++; if (rd_en !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ovfl_waiting got rd_en=%b busy=%b exp 0/1", rd_en, busy); end
        rd_rdy = 1'b1;
        wait_events(7, 7000);
        repeat (100) @(negedge clk);
        checks++; if (evt_n != 7) begin errors++; $display("FAIL ovfl_evt_count got %0d exp 7", evt_n); end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (ev_ovl[i] !== (6 - i >= 1) || ev_mov[i] !== (6 - i >= 2)) begin
                errors++;
                $display("FAIL ovfl_evt%0d_ovl got %b%b exp %b%b", i, ev_ovl[i], ev_mov[i], (6 - i >= 1), (6 - i >= 2));
            end
        end
        checks++; if (ovfl !== 1'b1) begin errors++; $display("FAIL ovfl_sticky got %b exp 1", ovfl); end
        checks++; if (pend_cnt !== 4'd0) begin errors++; $display("FAIL ovfl_pend_end got %0d exp 0", pend_cnt); end
        checks++; if (last_bad != 0 || data_bad != 0) begin errors++; $display("FAIL ovfl_last_data got %0d/%0d exp 0/0", last_bad, data_bad); end
    endtask

    task automatic test_reset_mid();
        int cnt = 0;
        int k = 0;
        int dv0;
        clear_mon();
        rd_rdy = 1'b1;
        l1a = 1'b1; @(negedge clk);
        l1a = 1'b0;
        while (cnt < 300 && k < 1200) begin
            @(negedge clk);
            k++;
            if (dvalid) cnt++;
            l1a = (cnt == 10);
        end
        l1a = 1'b0;
        checks++; if (cnt != 300) begin errors++; $display("FAIL rstmid_reach got %0d words exp 300", cnt); end
        checks++; if (pend_cnt !== 4'd1) begin errors++; $display("FAIL rstmid_pend_pre got %0d exp 1", pend_cnt); end
        rst = 1'b1;
        #1;
        checks++; if (dvalid !== 1'b0 || last_wrd !== 1'b0) begin errors++; $display("FAIL rstmid_dv_last got %b/%b exp 0/0", dvalid, last_wrd); end
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL rstmid_rd_en got %b exp 0", rd_en); end
        checks++; if (pend_cnt !== 4'd0) begin errors++; $display("FAIL rstmid_pend got %0d exp 0", pend_cnt); end
        checks++; if (ovfl !== 1'b0) begin errors++; $display("FAIL rstmid_ovfl got %b exp 0", ovfl); end
        @(negedge clk);
        rst = 1'b0;
        dv0 = dv_total;
        repeat (2000) @(negedge clk);
        checks++; if (dv_total != dv0) begin errors++; $display("FAIL rstmid_no_dv got %0d words exp 0", dv_total - dv0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_single();
        test_two();
        test_back_to_back();
        test_wait_rdy();
        test_ovfl();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
